cpu_debug_monitor: RTL and testbench

//  Synthesisable run-control/trace monitor beside the CPU core. Counts cycles and detects the HLT

---
 rtl/cpu_dbg_pkg.sv | 17 +
 rtl/dbg_cycle_watchdog.sv | 55 +++++
 rtl/cpu_debug_monitor.sv | 109 ++++++++++
 tb/tb_cpu_debug_monitor.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug monitor: dump FSM states, HLT opcode
// and default data-path sizes.
package cpu_dbg_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_NREGS  = 32;

  // Shared with the instruction decoder so both agree on what HLT is.
  localparam int HLT_OPCODE = 63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } dump_state_t;

endpackage

// File: rtl/dbg_cycle_watchdog.sv
// Cycle counter with halt capture and watchdog timeout for the debug monitor.
// halt_detect is the combinational "first HLT seen this cycle" strobe.
module dbg_cycle_watchdog
  import cpu_dbg_pkg::*;
#(
  parameter int OPCODE_W     = 6,
  parameter int HALT_OPCODE  = HLT_OPCODE,
  parameter int CNT_W        = 32,
  parameter int TIMEOUT      = 150,
  parameter int STOP_ON_HALT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                halt_detect,
  output logic [CNT_W-1:0]    cycle_count,
  output logic                halted,
  output logic [CNT_W-1:0]    halt_cycle,
  output logic                timeout
);

  localparam logic [OPCODE_W-1:0] HALT_OP    = OPCODE_W'(HALT_OPCODE);
  localparam logic [CNT_W-1:0]    TIMEOUT_M1 = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic count_hold;
  logic wdog_hit;

  assign halt_detect = (opcode == HALT_OP) && !halted;

  // The count also holds on the detect cycle so it keeps the captured halt value.
  assign count_hold = (STOP_ON_HALT != 0) && (halted || halt_detect);

  // A HLT on the expiry cycle takes priority, so the watchdog never fires then.
  assign wdog_hit = (TIMEOUT != 0) && !halted && !halt_detect && !timeout &&
                    (cycle_count == TIMEOUT_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      halted      <= 1'b0;
      halt_cycle  <= '0;
      timeout     <= 1'b0;
    end else begin
      if (!count_hold && (cycle_count != '1))
        cycle_count <= cycle_count + CNT_W'(1);
      if (halt_detect) begin
        halted     <= 1'b1;
        halt_cycle <= cycle_count;
      end
      if (wdog_hit)
        timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_debug_monitor.sv
// Run-control/trace monitor: cycle count, HLT capture, watchdog, and a
// valid/ready register-file dump triggered on request or on halt.
module cpu_debug_monitor
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int NREGS        = DEFAULT_NREGS,
  parameter int OPCODE_W     = 6,
  parameter int HALT_OPCODE  = HLT_OPCODE,
  parameter int CNT_W        = 32,
  parameter int TIMEOUT      = 150,
  parameter int AUTO_DUMP    = 1,
  parameter int STOP_ON_HALT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OPCODE_W-1:0]      opcode,
  input  logic                     dump_req,
  output logic [$clog2(NREGS)-1:0] rf_addr,
  input  logic [DATA_W-1:0]        rf_data,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [$clog2(NREGS)-1:0] dump_idx,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done,
  output logic [CNT_W-1:0]         cycle_count,
  output logic                     halted,
  output logic [CNT_W-1:0]         halt_cycle,
  output logic                     timeout
);

  localparam int IDX_W = $clog2(NREGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_SEND  = SEND;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             halt_detect;
  logic             trigger;

  dbg_cycle_watchdog #(
    .OPCODE_W    (OPCODE_W),
    .HALT_OPCODE (HALT_OPCODE),
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .STOP_ON_HALT(STOP_ON_HALT)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .halt_detect(halt_detect),
    .cycle_count(cycle_count),
    .halted     (halted),
    .halt_cycle (halt_cycle),
    .timeout    (timeout)
  );

  assign trigger = dump_req || ((AUTO_DUMP != 0) && halt_detect);
  assign rf_addr = idx;

  // Each entry costs a FETCH (register read) and at least one SEND cycle;
  // triggers arriving outside IDLE are dropped, not queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            idx   <= '0;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          dump_data  <= rf_data;
          dump_idx   <= idx;
          dump_valid <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              dump_done <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= ST_FETCH;
            end
          end
        end
        default: begin
          dump_valid <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_monitor.sv
// Directed self-checking bench for cpu_debug_monitor: watchdog/halt vector
// table plus hand-written dump, stall, reset-abort and saturation sequences.
module tb_cpu_debug_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        dump_req = 1'b0;
  logic        dump_ready = 1'b0;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        dump_valid;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_done;
  logic [31:0] cycle_count;
  logic        halted;
  logic [31:0] halt_cycle;
  logic        timeout;

  logic [5:0]  opcode2 = 6'd0;
  logic        dump_req2 = 1'b0;
  logic        dump_ready2 = 1'b0;
  logic [4:0]  rf_addr2;
  logic [31:0] rf_data2 = 32'd0;
  logic        dump_valid2;
  logic [4:0]  dump_idx2;
  logic [31:0] dump_data2;
  logic        dump_done2;
  logic [3:0]  cycle_count2;
  logic        halted2;
  logic [3:0]  halt_cycle2;
  logic        timeout2;

  logic [31:0] regs [32];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          hlt_at;
    int          run;
    logic [31:0] exp_count;
    logic        exp_halted;
    logic [31:0] exp_halt_cycle;
    logic        exp_timeout;
  } wd_vec_t;

  wd_vec_t vecs [8];

  cpu_debug_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .dump_req   (dump_req),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_done  (dump_done),
    .cycle_count(cycle_count),
    .halted     (halted),
    .halt_cycle (halt_cycle),
    .timeout    (timeout)
  );

  cpu_debug_monitor #(.CNT_W(4), .TIMEOUT(0)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode2),
    .dump_req   (dump_req2),
    .rf_addr    (rf_addr2),
    .rf_data    (rf_data2),
    .dump_valid (dump_valid2),
    .dump_ready (dump_ready2),
    .dump_idx   (dump_idx2),
    .dump_data  (dump_data2),
    .dump_done  (dump_done2),
    .cycle_count(cycle_count2),
    .halted     (halted2),
    .halt_cycle (halt_cycle2),
    .timeout    (timeout2)
  );

  always #5 clk = ~clk;

  assign rf_data = regs[rf_addr];

  function automatic logic [31:0] reg_value(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'hA500_0000 | (32'(i) << 8) | 32'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    opcode = 6'd0;
    dump_req = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic apply_stimulus(input wd_vec_t v);
    do_reset();
    dump_ready = 1'b1;
    for (int k = 0; k < v.run; k++) begin
      opcode = (k == v.hlt_at) ? 6'd63 : 6'd0;
      step();
    end
    opcode = 6'd0;
    check_output("vec_cycle_count", 64'(cycle_count), 64'(v.exp_count));
    check_output("vec_halted", 64'(halted), 64'(v.exp_halted));
    check_output("vec_halt_cycle", 64'(halt_cycle), 64'(v.exp_halt_cycle));
    check_output("vec_timeout", 64'(timeout), 64'(v.exp_timeout));
    if (!v.exp_halted)
      check_output("vec_dump_valid_idle", 64'(dump_valid), 64'd0);
  endtask

  // Runs a fixed window, checking every accepted entry against the register
  // model; optionally stalls one index and pokes dump_req mid-dump.
  task automatic collect_dump(input int stall_idx, input int stall_len, input int poke_idx,
                              output int entries, output int dones);
    int stalled;
    int poke_left;
    entries = 0;
    dones = 0;
    stalled = 0;
    poke_left = 0;
    for (int c = 0; c < 200; c++) begin
      dump_req = (poke_left > 0);
      if (poke_left > 0) poke_left--;
      dump_ready = 1'b1;
      if (dump_valid) begin
        if (32'(dump_idx) == stall_idx && stalled < stall_len) begin
          dump_ready = 1'b0;
          stalled++;
          check_output("stall_idx", 64'(dump_idx), 64'(stall_idx));
          check_output("stall_data", 64'(dump_data), 64'(reg_value(stall_idx)));
        end else begin
          check_output("entry_idx", 64'(dump_idx), 64'(entries));
          check_output("entry_data", 64'(dump_data), 64'(reg_value(entries)));
          if (entries == poke_idx) poke_left = 2;
          entries++;
        end
      end
      if (dump_done) dones++;
      step();
    end
    dump_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int entries;
    int dones;
    int valids;
    int found;

    for (int i = 0; i < 32; i++) regs[i] = reg_value(i);

    vecs[0] = '{-1,  10, 32'd10,  1'b0, 32'd0,   1'b0};
    vecs[1] = '{-1,  149, 32'd149, 1'b0, 32'd0,   1'b0};
    vecs[2] = '{-1,  150, 32'd150, 1'b0, 32'd0,   1'b1};
    vecs[3] = '{149, 160, 32'd149, 1'b1, 32'd149, 1'b0};
    vecs[4] = '{148, 160, 32'd148, 1'b1, 32'd148, 1'b0};
    vecs[5] = '{0,   5,   32'd0,   1'b1, 32'd0,   1'b0};
    vecs[6] = '{-1,  200, 32'd200, 1'b0, 32'd0,   1'b1};
    vecs[7] = '{42,  50,  32'd42,  1'b1, 32'd42,  1'b0};

    // Reset state
    do_reset();
    check_output("rst_cycle_count", 64'(cycle_count), 64'd0);
    check_output("rst_halted", 64'(halted), 64'd0);
    check_output("rst_timeout", 64'(timeout), 64'd0);
    check_output("rst_dump_valid", 64'(dump_valid), 64'd0);
    check_output("rst_dump_done", 64'(dump_done), 64'd0);
    check_output("rst_rf_addr", 64'(rf_addr), 64'd0);

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // HLT at count 42 with automatic dump of all 32 registers
    do_reset();
    dump_ready = 1'b1;
    repeat (42) step();
    opcode = 6'd63;
    step();
    opcode = 6'd0;
    check_output("halt_halted", 64'(halted), 64'd1);
    check_output("halt_cycle", 64'(halt_cycle), 64'd42);
    check_output("halt_count_frozen", 64'(cycle_count), 64'd42);
    check_output("halt_fetch_not_valid", 64'(dump_valid), 64'd0);
    step();
    check_output("auto_first_valid", 64'(dump_valid), 64'd1);
    collect_dump(-1, 0, -1, entries, dones);
    check_output("auto_entries", 64'(entries), 64'd32);
    check_output("auto_dones", 64'(dones), 64'd1);
    check_output("auto_count_still_42", 64'(cycle_count), 64'd42);
    opcode = 6'd63;
    step();
    opcode = 6'd0;
    check_output("second_hlt_ignored", 64'(halt_cycle), 64'd42);

    // Requested dump with a 4-cycle stall at idx 5 and a mid-dump request
    do_reset();
    dump_ready = 1'b1;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    check_output("req_fetch_not_valid", 64'(dump_valid), 64'd0);
    step();
    check_output("req_first_valid", 64'(dump_valid), 64'd1);
    collect_dump(5, 4, 10, entries, dones);
    check_output("req_entries", 64'(entries), 64'd32);
    check_output("req_dones", 64'(dones), 64'd1);

    // Reset while presenting idx 17 abandons the dump
    do_reset();
    dump_ready = 1'b1;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      if (dump_valid && dump_idx == 5'd17) found = 1;
      else step();
    end
    check_output("abort_reached_17", 64'(found), 64'd1);
    dump_ready = 1'b0;
    rst = 1'b1;
    step();
    check_output("abort_dump_valid", 64'(dump_valid), 64'd0);
    check_output("abort_cycle_count", 64'(cycle_count), 64'd0);
    check_output("abort_dump_done", 64'(dump_done), 64'd0);
    rst = 1'b0;
    dump_ready = 1'b1;
    dones = 0;
    valids = 0;
    repeat (40) begin
      step();
      if (dump_done) dones++;
      if (dump_valid) valids++;
    end
    check_output("abort_no_done", 64'(dones), 64'd0);
    check_output("abort_no_valid", 64'(valids), 64'd0);

    // 4-bit counter with watchdog disabled saturates at 15
    do_reset();
    repeat (14) step();
    check_output("sat_count_14", 64'(cycle_count2), 64'd14);
    step();
    check_output("sat_count_15", 64'(cycle_count2), 64'd15);
    repeat (20) step();
    check_output("sat_count_held", 64'(cycle_count2), 64'd15);
    check_output("sat_no_timeout", 64'(timeout2), 64'd0);
    check_output("sat_not_halted", 64'(halted2), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
